uart_tx_fifo: RTL

Parametrised, FIFO-buffered UART transmitter. It is the next generation of the team's fixed 8N1 transmitter.
- Accepts words over a valid/ready handshake into an internal FIFO and serialises them back-to-back on a single TX line.
- Data width, parity mode and stop-bit count are configurable.
- Sits between CPU/MMIO logic and the board UART pin. It removes the need for software to poll busy per byte.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, tx state enum and timing helpers
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   function automatic int cycles_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int frame_cycles(input int data_bits, input int parity,
                                       input int stop_bits, input int cpb);
      return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * cpb;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with combinational head read
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign wr_en = push && !full;
   assign rd_en = pop && !empty;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with configurable frame
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD_RT    = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_BITS-1:0]          in_data,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int               CPB       = cycles_per_bit(CLK_HZ, BAUD_RT);
   localparam int               CNT_W     = $clog2(CPB);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CPB - 1);
   localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
   localparam bit               HAS_PAR   = (PARITY != PAR_NONE);
   localparam bit               ODD_PAR   = (PARITY == PAR_ODD);

   tx_state_t            state;
   tx_state_t            next_state;
   logic [CNT_W-1:0]     cnt;
   logic [3:0]           bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 shift;
   logic                 tx_next;
   logic                 bit_end;
   logic                 last_data;
   logic                 last_stop;

   assign in_ready  = !fifo_full;
   assign push      = in_valid && in_ready;
   assign bit_end   = (cnt == LAST_CNT);
   assign last_data = (bit_cnt == LAST_BIT);
   assign last_stop = (stop_cnt == LAST_STOP);
   assign busy      = (state != ST_IDLE) || (fifo_count != '0);

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (!fifo_empty) next_state = ST_START;
         ST_START:  if (bit_end) next_state = ST_DATA;
         ST_DATA:   if (bit_end && last_data) next_state = HAS_PAR ? ST_PARITY : ST_STOP;
         ST_PARITY: if (bit_end) next_state = ST_STOP;
         ST_STOP:   if (bit_end && last_stop) next_state = fifo_empty ? ST_IDLE : ST_START;
         default:   next_state = ST_IDLE;
      endcase
   end

   // A new frame may start straight out of the last stop bit, giving no idle gap.
   always_comb begin
      pop     = 1'b0;
      shift   = 1'b0;
      tx_next = tx;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               tx_next = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               shift   = 1'b1;
               tx_next = shreg[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift   = !last_data;
               tx_next = last_data ? (HAS_PAR ? par_bit : 1'b1) : shreg[0];
            end
         end
         ST_PARITY: begin
            if (bit_end) tx_next = 1'b1;
         end
         ST_STOP: begin
            if (bit_end && last_stop) begin
               pop     = !fifo_empty;
               tx_next = fifo_empty;
            end
         end
         default: tx_next = 1'b1;
      endcase
   end

   // Baud counter is held at zero while idle so every start bit is full length.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx       <= 1'b1;
         cnt      <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
      end else begin
         tx  <= tx_next;
         cnt <= (state == ST_IDLE || bit_end) ? '0 : cnt + 1'b1;
         if (pop) begin
            shreg   <= fifo_rdata;
            par_bit <= (^fifo_rdata) ^ ODD_PAR;
         end else if (shift) begin
            shreg <= shreg >> 1;
         end
         if (state == ST_START)              bit_cnt <= '0;
         else if (state == ST_DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
         if (state != ST_STOP)  stop_cnt <= 1'b0;
         else if (bit_end)      stop_cnt <= ~stop_cnt;
      end
   end

endmodule
